// File: rtl/uart_pkg.sv
// Types and defaults shared by the transmit arbiter and the tx_fsm transmitter.
package uart_pkg;

    localparam int UART_DATA_W = 160;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selection: first requester above last_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    logic [2*NUM_REQ-1:0] req_dbl;

    always_comb begin
        req_dbl = {req, req};
        winner  = '0;
        valid   = 1'b0;
        // Window last_ptr+1 .. last_ptr+NUM_REQ of the doubled vector; scanning
        // downward lets the lowest qualifying position overwrite the others.
        for (int unsigned j = 2 * NUM_REQ; j > 0; j--) begin
            if (req_dbl[j-1] && (j - 1 > 32'(last_ptr)) &&
                (j - 1 <= 32'(last_ptr) + 32'(NUM_REQ))) begin
                valid  = 1'b1;
                winner = (j - 1 >= 32'(NUM_REQ)) ? PTR_W'(j - 1 - 32'(NUM_REQ))
                                                 : PTR_W'(j - 1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one tx_fsm transmitter among NUM_REQ requesters with round-robin
// grants, a start timeout while loading, and a done pulse per completed frame.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = UART_DATA_W,
    parameter int START_TMO = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      wr_enable,
    input  logic                      tx_busy,
    output logic                      timeout_err
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W  = $clog2(START_TMO + 1);
    localparam int CNT_W  = (TMO_W > 8) ? TMO_W : 8;

    arb_state_t          state, state_nxt;
    logic [NUM_REQ-1:0]  grant_nxt, done_nxt;
    logic [DATA_W-1:0]   tx_data_nxt;
    logic                wr_nxt, tmo_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [PTR_W-1:0]    last_ptr, last_nxt;
    logic [PTR_W-1:0]    owner, owner_nxt;
    logic [PTR_W-1:0]    pick_winner;
    logic                pick_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req      (req),
        .last_ptr (last_ptr),
        .winner   (pick_winner),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            done        <= '0;
            tx_data     <= '0;
            wr_enable   <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            last_ptr    <= PTR_W'(NUM_REQ - 1);
            owner       <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            done        <= done_nxt;
            tx_data     <= tx_data_nxt;
            wr_enable   <= wr_nxt;
            timeout_err <= tmo_nxt;
            cnt         <= cnt_nxt;
            last_ptr    <= last_nxt;
            owner       <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        done_nxt    = '0;
        tx_data_nxt = tx_data;
        wr_nxt      = wr_enable;
        tmo_nxt     = 1'b0;
        cnt_nxt     = cnt;
        last_nxt    = last_ptr;
        owner_nxt   = owner;

        case (state)
            IDLE: begin
                if (pick_valid && tx_busy) begin
                    grant_nxt   = NUM_REQ'(1) << pick_winner;
                    tx_data_nxt = req_data[pick_winner * DATA_W +: DATA_W];
                    wr_nxt      = 1'b1;
                    cnt_nxt     = '0;
                    owner_nxt   = pick_winner;
                    state_nxt   = LOAD;
                end
            end
            LOAD: begin
                // A start seen on the final counted cycle still wins over timeout.
                if (!tx_busy) begin
                    wr_nxt    = 1'b0;
                    state_nxt = SEND;
                end else if (cnt == CNT_W'(START_TMO - 1)) begin
                    wr_nxt    = 1'b0;
                    grant_nxt = '0;
                    tmo_nxt   = 1'b1;
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SEND: begin
                if (tx_busy) begin
                    done_nxt  = grant;
                    grant_nxt = '0;
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, corner sequences and a
// randomized run against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 160;
    localparam int START_TMO = 255;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         tx_data;
    logic                      wr_enable;
    logic                      tx_busy;
    logic                      timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NUM_REQ-1:0] r;
        int                 sdly;
        int                 len;
        int                 exp_idx;
    } vec_t;

    vec_t tbl[11];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .START_TMO (START_TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .done        (done),
        .tx_data     (tx_data),
        .wr_enable   (wr_enable),
        .tx_busy     (tx_busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            checks++;
            if (!$onehot0(grant) || !$onehot0(done)) begin
                errors++;
                $display("FAIL onehot: grant %b done %b, required at most one bit each", grant, done);
            end
        end
    end

    function automatic int rr_model(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++)
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < NUM_REQ * DATA_W / 32; i++) req_data[i*32 +: 32] = $urandom();
    endtask

    task automatic reset_dut(input logic busy, input logic [NUM_REQ-1:0] r, input bit chk);
        reset_n = 1'b0;
        req     = r;
        tx_busy = busy;
        @(negedge clk);
        if (chk) begin
            check("rst_grant", DATA_W'(grant), '0);
            check("rst_done", DATA_W'(done), '0);
            check("rst_wr", DATA_W'(wr_enable), '0);
            check("rst_tx_data", tx_data, '0);
            check("rst_tmo", DATA_W'(timeout_err), '0);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One transaction with a modelled transmitter. sdly<0: never start (timeout).
    task automatic run_frame(input logic [NUM_REQ-1:0] r, input int sdly, input int len,
                             output logic [NUM_REQ-1:0] g, output logic [DATA_W-1:0] d);
        int wr_cnt, done_cnt, tmo_cnt, unstable;
        bit seen;
        g = '0;
        d = '0;
        req = r;
        tx_busy = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (wr_enable) seen = 1'b1;
        end
        check("wr_start", DATA_W'(seen), DATA_W'(1'b1));
        if (!seen) return;
        g = grant;
        d = tx_data;
        wr_cnt = 1; done_cnt = 0; tmo_cnt = 0; unstable = 0;
        if (sdly < 0) begin
            for (int n = 0; n < 300 && tmo_cnt == 0; n++) begin
                rand_data();
                @(negedge clk);
                if (timeout_err) tmo_cnt++;
                else if (grant !== g || tx_data !== d) unstable++;
                if (wr_enable) wr_cnt++;
                if (|done) done_cnt++;
            end
            check("tmo_pulse", DATA_W'(tmo_cnt), DATA_W'(1));
            check("tmo_wr_cycles", DATA_W'(wr_cnt), DATA_W'(START_TMO));
            check("tmo_no_done", DATA_W'(done_cnt), '0);
            check("tmo_grant_clr", DATA_W'(grant), '0);
        end else begin
            for (int n = 1; n < sdly; n++) begin
                req = NUM_REQ'($urandom());
                rand_data();
                @(negedge clk);
                if (wr_enable) wr_cnt++;
                if (grant !== g || tx_data !== d) unstable++;
            end
            tx_busy = 1'b0;
            for (int n = 0; n < len; n++) begin
                req = NUM_REQ'($urandom());
                rand_data();
                @(negedge clk);
                if (wr_enable) wr_cnt++;
                if (|done) done_cnt++;
                if (timeout_err) tmo_cnt++;
                if (grant !== g || tx_data !== d) unstable++;
            end
            tx_busy = 1'b1;
            seen = 1'b0;
            for (int n = 0; n < 5 && !seen; n++) begin
                @(negedge clk);
                if (wr_enable) wr_cnt++;
                if (timeout_err) tmo_cnt++;
                if (|done) begin
                    seen = 1'b1;
                    check("done_owner", DATA_W'(done), DATA_W'(g));
                    check("done_grant_clr", DATA_W'(grant), '0);
                end else if (grant !== g || tx_data !== d) unstable++;
            end
            check("done_seen", DATA_W'(seen), DATA_W'(1'b1));
            check("early_done", DATA_W'(done_cnt), '0);
            check("wr_cycles", DATA_W'(wr_cnt), DATA_W'(sdly));
            check("no_tmo", DATA_W'(tmo_cnt), '0);
        end
        check("hold_grant_data", DATA_W'(unstable), '0);
    endtask

    initial begin
        logic [NUM_REQ-1:0] g, r;
        logic [DATA_W-1:0]  d, exp_d;
        int mlast, idx, sdly, len;

        tbl[0]  = '{4'b1111, 2, 6, 0};
        tbl[1]  = '{4'b1111, 1, 3, 1};
        tbl[2]  = '{4'b1111, 3, 8, 2};
        tbl[3]  = '{4'b1111, 2, 1, 3};
        tbl[4]  = '{4'b1111, 4, 5, 0};
        tbl[5]  = '{4'b1001, 1, 2, 3};
        tbl[6]  = '{4'b0110, 2, 4, 1};
        tbl[7]  = '{4'b0001, 3, 2, 0};
        tbl[8]  = '{4'b1100, 1, 7, 2};
        tbl[9]  = '{4'b0100, -1, 0, 2};
        tbl[10] = '{4'b1111, 2, 3, 3};

        rand_data();
        reset_dut(1'b1, '0, 1'b1);

        // Single request, long frame.
        exp_d = req_data[0 +: DATA_W];
        run_frame(4'b0001, 2, 170, g, d);
        check("single_grant", DATA_W'(g), DATA_W'(4'b0001));
        check("single_data", d, exp_d);
        req = '0;
        @(negedge clk);
        check("single_done_once", DATA_W'(done), '0);

        // Directed table: fairness, wrap-around and timeout hand-off.
        reset_dut(1'b1, '0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            exp_d = req_data[tbl[i].exp_idx * DATA_W +: DATA_W];
            run_frame(tbl[i].r, tbl[i].sdly, tbl[i].len, g, d);
            check($sformatf("tbl%0d_grant", i), DATA_W'(g), DATA_W'(1 << tbl[i].exp_idx));
            check($sformatf("tbl%0d_data", i), d, exp_d);
        end

        // Busy gating at reset release.
        reset_dut(1'b0, 4'b0010, 1'b0);
        repeat (4) @(negedge clk);
        check("gate_no_grant", DATA_W'(grant), '0);
        check("gate_no_wr", DATA_W'(wr_enable), '0);
        tx_busy = 1'b1;
        @(negedge clk);
        check("gate_grant", DATA_W'(grant), DATA_W'(4'b0010));
        check("gate_wr", DATA_W'(wr_enable), DATA_W'(1'b1));

        // Withdrawn request is never granted.
        reset_dut(1'b0, 4'b0001, 1'b0);
        repeat (3) @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        tx_busy = 1'b1;
        @(negedge clk);
        check("withdraw_grant", DATA_W'(grant), DATA_W'(4'b0100));

        // Reset during SEND abandons the frame.
        reset_dut(1'b1, 4'b0110, 1'b0);
        @(negedge clk);
        check("ms_grant", DATA_W'(grant), DATA_W'(4'b0010));
        @(negedge clk);
        tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("ms_in_send", DATA_W'({wr_enable, grant}), DATA_W'(5'b00010));
        reset_n = 1'b0;
        tx_busy = 1'b1;
        @(negedge clk);
        check("ms_rst_grant", DATA_W'(grant), '0);
        check("ms_rst_done", DATA_W'(done), '0);
        check("ms_rst_wr", DATA_W'(wr_enable), '0);
        check("ms_rst_data", tx_data, '0);
        check("ms_rst_tmo", DATA_W'(timeout_err), '0);
        reset_n = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        check("ms_next_grant", DATA_W'(grant), DATA_W'(4'b0001));
        check("ms_next_done", DATA_W'(done), '0);

        // Randomized traffic against the round-robin model.
        reset_dut(1'b1, '0, 1'b0);
        mlast = NUM_REQ - 1;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = '0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                check("rnd_idle", DATA_W'({wr_enable, grant}), '0);
            end
            r     = NUM_REQ'($urandom_range(1, 15));
            idx   = rr_model(r, mlast);
            exp_d = req_data[idx * DATA_W +: DATA_W];
            sdly  = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(1, 4));
            len   = $urandom_range(1, 12);
            run_frame(r, sdly, len, g, d);
            check($sformatf("rnd%0d_grant", t), DATA_W'(g), DATA_W'(1 << idx));
            check($sformatf("rnd%0d_data", t), d, exp_d);
            mlast = idx;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one tx_fsm transmitter.
REQ-002 The block SHALL have parameter DATA_W, default 160, meaning the frame width in bits, equal to the tx_fsm data width.
REQ-003 The block SHALL have parameter START_TMO, default 255, meaning the maximum number of cycles wr_enable is held before the transmitter must start.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: per-requester transmit request, level, held until done.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_W bits: requester i frame at bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port grant, output, NUM_REQ bits: one-hot owner of the transmitter, all-zero when idle.
REQ-009 The block SHALL have port done, output, NUM_REQ bits: one-cycle pulse to the owner on frame completion.
REQ-010 The block SHALL have port tx_data, output, DATA_W bits: frame to the transmitter, registered.
REQ-011 The block SHALL have port wr_enable, output, 1 bit: load request to the transmitter.
REQ-012 The block SHALL have port tx_busy, input, 1 bit: transmitter status; 1 = idle or finished, 0 = frame in progress.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when the transmitter fails to start within START_TMO cycles.

Function
REQ-014 The block SHALL implement the states IDLE, LOAD and SEND.
REQ-015 In IDLE, when req is non-zero and tx_busy=1, the block SHALL select a winner round-robin, searching from last_ptr+1 upward with wrap-around.
REQ-016 In the same IDLE edge, the block SHALL register grant as one-hot(winner), tx_data as the winner's slice and wr_enable=1, and move to LOAD; latency from req to wr_enable is 1 cycle.
REQ-017 In IDLE with tx_busy=0, the block SHALL grant nothing, even if req is non-zero.
REQ-018 In LOAD, wr_enable SHALL be held at 1; when tx_busy=0 is sampled, the block SHALL clear wr_enable and move to SEND.
REQ-019 In LOAD, an 8-bit-minimum cycle counter SHALL increment; on reaching START_TMO, the block SHALL clear wr_enable and grant, pulse timeout_err, set last_ptr to the winner, and return to IDLE without pulsing done.
REQ-020 In SEND, when tx_busy=1 is sampled, the block SHALL pulse done[winner] for one cycle, clear grant, set last_ptr to the winner, and return to IDLE.
REQ-021 tx_data and grant SHALL remain stable from the grant edge until the return to IDLE.
REQ-022 Changes to req or req_data of the owner during LOAD or SEND SHALL be ignored; the captured frame completes.
REQ-023 A request that is deasserted before it is selected SHALL never be granted.
REQ-024 A requester still asserting req on the done cycle SHALL be re-arbitrated normally; round-robin then gives the other requesters priority.
REQ-025 The minimum spacing between consecutive grants SHALL be 1 IDLE cycle after done.
REQ-026 At most one bit of grant and one bit of done SHALL be set at any time.

Reset
REQ-027 On any clk edge with reset_n=0, the block SHALL set state=IDLE, grant=0, done=0, wr_enable=0, tx_data=0, timeout_err=0, the counter to 0 and last_ptr=NUM_REQ-1, so that requester 0 wins first.
REQ-028 A reset during LOAD or SEND SHALL abandon the frame without pulsing done or timeout_err.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum typedef and the DATA_W default shared with tx_fsm.
REQ-030 The combinational round-robin pick (req, last_ptr -> winner, valid) SHALL be sub-module rr_pick.

Verification
REQ-031 Single request: req=4'b0001, tx_busy drops 2 cycles after wr_enable and rises 170 cycles later -> grant=0001, tx_data equals slice 0, exactly one done[0] pulse, wr_enable high for exactly 2 cycles.
REQ-032 Fairness: req=4'b1111 held, model transmitter -> grant order 0,1,2,3,0, with one done per frame.
REQ-033 Timeout: req=4'b0100, tx_busy held at 1 -> wr_enable high for 255 cycles, then timeout_err pulse, grant=0, no done; the next grant goes to requester 3 if it is requesting.
REQ-034 Busy gating: tx_busy=0 at reset release with req=4'b0010 -> no grant until tx_busy=1, then grant=0010 on the next edge.
REQ-035 Reset mid-SEND: reset_n low for 1 cycle during SEND -> all outputs 0, no done pulse, and the next grant goes to requester 0.
REQ-036 Data hold: change req_data[0] during SEND -> tx_data unchanged until the return to IDLE.
